serv_rf_if_seq: RTL and testbench

Next-generation register-file interface for the bit/nibble-serial core. It maps rd, rs1/rs2 and CSR/trap accesses onto a GPR+CSR RF with a parametrised datapath width W and a parametrised CSR count. It adds a programmable trap-address hold counter. It also supports a single-write-port RF mode that buffers the secondary write stream and replays it after the instruction, stalling the core through o_busy.

---
 rtl/serv_rf_pkg.sv | 9 +
 rtl/serv_rf_replay_buf.sv | 66 ++++++
 rtl/serv_rf_if_seq.sv | 106 ++++++++++
 tb/tb_serv_rf_if_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serv_rf_pkg.sv
// serv_rf_pkg: shared RF address map, address width and replay FSM states
package serv_rf_pkg;
    localparam int RF_AW = 6;
    localparam logic [RF_AW-1:0] CSR_MSCRATCH = 6'd32;
    localparam logic [RF_AW-1:0] CSR_MTVEC    = 6'd33;
    localparam logic [RF_AW-1:0] CSR_MEPC     = 6'd34;
    localparam logic [RF_AW-1:0] CSR_MTVAL    = 6'd35;
    typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY} rf_state_e;
endpackage

// File: rtl/serv_rf_replay_buf.sv
// serv_rf_replay_buf: captures the secondary write stream and replays it on the single write port
module serv_rf_replay_buf
    import serv_rf_pkg::*;
#(
    parameter int W = 1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_cnt_en,
    input  logic             i_cnt_done,
    input  logic             i_wen,
    input  logic [RF_AW-1:0] i_waddr,
    input  logic [W-1:0]     i_wdata,
    output logic             o_busy,
    output logic [RF_AW-1:0] o_waddr,
    output logic [W-1:0]     o_wdata
);
    localparam int BEATS = 32 / W;
    rf_state_e        state_q, state_d;
    logic [31:0]      buf_q, buf_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [RF_AW-1:0] addr_q, addr_d;
    logic             shift_in;
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        shift_in = i_cnt_en & i_wen;
        case (state_q)
            IDLE: if (shift_in) begin
                buf_d   = {i_wdata, buf_q[31:W]};
                addr_d  = i_waddr;
                cnt_d   = 5'(BEATS - 1);
                state_d = i_cnt_done ? REPLAY : CAPTURE;
            end
            CAPTURE: begin
                buf_d   = shift_in ? {i_wdata, buf_q[31:W]} : buf_q;
                cnt_d   = 5'(BEATS - 1);
                state_d = i_cnt_done ? REPLAY : CAPTURE;
            end
            REPLAY: begin
                buf_d   = buf_q >> W;
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q == 5'd0) ? IDLE : REPLAY;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end
    assign o_busy  = (state_q == REPLAY);
    assign o_waddr = addr_q;
    assign o_wdata = buf_q[W-1:0];
endmodule

// File: rtl/serv_rf_if_seq.sv
// serv_rf_if_seq: maps rd, rs1/rs2 and CSR/trap accesses onto a GPR+CSR register file
module serv_rf_if_seq
    import serv_rf_pkg::*;
#(
    parameter int W         = 1,
    parameter int CSR_REGS  = 4,
    parameter int CA        = $clog2(CSR_REGS),
    parameter int TRAP_HOLD = 2,
    parameter int WR_PORTS  = 2
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_cnt_en,
    input  logic             i_cnt_done,
    output logic             o_busy,
    output logic [RF_AW-1:0] o_wreg0,
    output logic [RF_AW-1:0] o_wreg1,
    output logic             o_wen0,
    output logic             o_wen1,
    output logic [W-1:0]     o_wdata0,
    output logic [W-1:0]     o_wdata1,
    output logic [RF_AW-1:0] o_rreg0,
    output logic [RF_AW-1:0] o_rreg1,
    input  logic [W-1:0]     i_rdata0,
    input  logic [W-1:0]     i_rdata1,
    input  logic             i_trap,
    input  logic             i_mret,
    input  logic             i_mtval_pc,
    input  logic [W-1:0]     i_mepc,
    input  logic [W-1:0]     i_bufreg_q,
    input  logic [W-1:0]     i_bad_pc,
    output logic [W-1:0]     o_csr_pc,
    input  logic             i_csr_en,
    input  logic [CA-1:0]    i_csr_addr,
    input  logic [W-1:0]     i_csr,
    output logic [W-1:0]     o_csr,
    input  logic             i_rd_wen,
    input  logic [4:0]       i_rd_waddr,
    input  logic [W-1:0]     i_ctrl_rd,
    input  logic [W-1:0]     i_alu_rd,
    input  logic [W-1:0]     i_csr_rd,
    input  logic [W-1:0]     i_mem_rd,
    input  logic             i_rd_alu_en,
    input  logic             i_rd_csr_en,
    input  logic             i_rd_mem_en,
    input  logic [4:0]       i_rs1_raddr,
    input  logic [4:0]       i_rs2_raddr,
    output logic [W-1:0]     o_rs1,
    output logic [W-1:0]     o_rs2
);
    logic [3:0]       hold_q, hold_d;
    logic [W-1:0]     rd, pdata, sdata, rb_wdata;
    logic [RF_AW-1:0] paddr, saddr, csr_reg, rb_waddr;
    logic             rd_wen, pen, sen, trap_d, rb_busy;
    always_comb begin
        rd      = i_ctrl_rd | (i_alu_rd & {W{i_rd_alu_en}}) | (i_csr_rd & {W{i_rd_csr_en}})
                | (i_mem_rd & {W{i_rd_mem_en}});
        rd_wen  = i_rd_wen & (i_rd_waddr != 5'd0);
        hold_d  = i_trap ? 4'(TRAP_HOLD) : (hold_q != 4'd0) ? hold_q - 4'd1 : 4'd0;
        trap_d  = i_trap | (hold_q != 4'd0);
        csr_reg = CSR_MSCRATCH + 6'(i_csr_addr);
        pdata   = i_trap ? (i_mtval_pc ? i_bad_pc : i_bufreg_q) : rd;
        paddr   = trap_d ? CSR_MTVAL : {1'b0, i_rd_waddr};
        pen     = i_trap | rd_wen;
        sdata   = i_trap ? i_mepc : i_csr;
        saddr   = trap_d ? CSR_MEPC : csr_reg;
        sen     = i_trap | i_csr_en;
        o_busy   = rb_busy;
        o_wen0   = i_rst_n & (rb_busy | (i_cnt_en & pen));
        o_wreg0  = rb_busy ? rb_waddr : paddr;
        o_wdata0 = rb_busy ? rb_wdata : pdata;
        o_wen1   = i_rst_n & (WR_PORTS == 2) & i_cnt_en & sen;
        o_wreg1  = saddr;
        o_wdata1 = sdata;
        o_rreg0  = {1'b0, i_rs1_raddr};
        o_rreg1  = i_trap ? CSR_MTVEC : i_mret ? CSR_MEPC : i_csr_en ? csr_reg : {1'b0, i_rs2_raddr};
        o_rs1    = i_rdata0;
        o_rs2    = i_rdata1;
        o_csr_pc = i_rdata1;
        o_csr    = i_rdata1 & {W{i_csr_en}};
    end
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) hold_q <= '0;
        else          hold_q <= hold_d;
    end
    if (WR_PORTS == 1) begin : g_replay
        serv_rf_replay_buf #(.W(W)) u_replay (
            .clk        (clk),
            .i_rst_n    (i_rst_n),
            .i_cnt_en   (i_cnt_en),
            .i_cnt_done (i_cnt_done),
            .i_wen      (sen),
            .i_waddr    (saddr),
            .i_wdata    (sdata),
            .o_busy     (rb_busy),
            .o_waddr    (rb_waddr),
            .o_wdata    (rb_wdata)
        );
    end else begin : g_direct
        logic unused_done;
        assign unused_done = i_cnt_done;
        assign rb_busy  = 1'b0;
        assign rb_waddr = '0;
        assign rb_wdata = '0;
    end
endmodule

// File: tb/tb_serv_rf_if_seq.sv
// tb_serv_rf_if_seq: directed checks of a W=1 dual-port instance and a W=4 single-port replay instance
module tb_serv_rf_if_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst_n, cnt_en, cnt_done, trap, mret, mtval_pc, csr_en, rd_wen, alu_en, csr_rd_en, mem_en;
    logic [2:0] csr_addr;
    logic [4:0] rd_waddr, rs1, rs2;
    logic [7:0] rdata0, rdata1, mepc, bufreg, bad_pc, csr_w, ctrl_rd, alu_rd, csr_rd, mem_rd;
    logic       a_busy, a_wen0, a_wen1, b_busy, b_wen0, b_wen1;
    logic [5:0] a_wreg0, a_wreg1, a_rreg0, a_rreg1, b_wreg0, b_wreg1, b_rreg0, b_rreg1;
    logic [0:0] a_wdata0, a_wdata1, a_csr_pc, a_csr, a_rs1, a_rs2;
    logic [3:0] b_wdata0, b_wdata1, b_csr_pc, b_csr, b_rs1, b_rs2;
    int n_checks = 0;
    int n_fail = 0;

    serv_rf_if_seq #(.W(1), .CSR_REGS(8), .TRAP_HOLD(3), .WR_PORTS(2)) dut_a (
        .clk(clk), .i_rst_n(rst_n), .i_cnt_en(cnt_en), .i_cnt_done(cnt_done), .o_busy(a_busy),
        .o_wreg0(a_wreg0), .o_wreg1(a_wreg1), .o_wen0(a_wen0), .o_wen1(a_wen1),
        .o_wdata0(a_wdata0), .o_wdata1(a_wdata1), .o_rreg0(a_rreg0), .o_rreg1(a_rreg1),
        .i_rdata0(rdata0[0:0]), .i_rdata1(rdata1[0:0]), .i_trap(trap), .i_mret(mret),
        .i_mtval_pc(mtval_pc), .i_mepc(mepc[0:0]), .i_bufreg_q(bufreg[0:0]), .i_bad_pc(bad_pc[0:0]),
        .o_csr_pc(a_csr_pc), .i_csr_en(csr_en), .i_csr_addr(csr_addr), .i_csr(csr_w[0:0]), .o_csr(a_csr),
        .i_rd_wen(rd_wen), .i_rd_waddr(rd_waddr), .i_ctrl_rd(ctrl_rd[0:0]), .i_alu_rd(alu_rd[0:0]),
        .i_csr_rd(csr_rd[0:0]), .i_mem_rd(mem_rd[0:0]), .i_rd_alu_en(alu_en), .i_rd_csr_en(csr_rd_en),
        .i_rd_mem_en(mem_en), .i_rs1_raddr(rs1), .i_rs2_raddr(rs2), .o_rs1(a_rs1), .o_rs2(a_rs2)
    );

    serv_rf_if_seq #(.W(4), .CSR_REGS(4), .TRAP_HOLD(2), .WR_PORTS(1)) dut_b (
        .clk(clk), .i_rst_n(rst_n), .i_cnt_en(cnt_en), .i_cnt_done(cnt_done), .o_busy(b_busy),
        .o_wreg0(b_wreg0), .o_wreg1(b_wreg1), .o_wen0(b_wen0), .o_wen1(b_wen1),
        .o_wdata0(b_wdata0), .o_wdata1(b_wdata1), .o_rreg0(b_rreg0), .o_rreg1(b_rreg1),
        .i_rdata0(rdata0[3:0]), .i_rdata1(rdata1[3:0]), .i_trap(trap), .i_mret(mret),
        .i_mtval_pc(mtval_pc), .i_mepc(mepc[3:0]), .i_bufreg_q(bufreg[3:0]), .i_bad_pc(bad_pc[3:0]),
        .o_csr_pc(b_csr_pc), .i_csr_en(csr_en), .i_csr_addr(csr_addr[1:0]), .i_csr(csr_w[3:0]), .o_csr(b_csr),
        .i_rd_wen(rd_wen), .i_rd_waddr(rd_waddr), .i_ctrl_rd(ctrl_rd[3:0]), .i_alu_rd(alu_rd[3:0]),
        .i_csr_rd(csr_rd[3:0]), .i_mem_rd(mem_rd[3:0]), .i_rd_alu_en(alu_en), .i_rd_csr_en(csr_rd_en),
        .i_rd_mem_en(mem_en), .i_rs1_raddr(rs1), .i_rs2_raddr(rs2), .o_rs1(b_rs1), .o_rs2(b_rs2)
    );

    task automatic clear_inputs;
        cnt_en = 0; cnt_done = 0; trap = 0; mret = 0; mtval_pc = 0; csr_en = 0; rd_wen = 0;
        alu_en = 0; csr_rd_en = 0; mem_en = 0; csr_addr = 0; rd_waddr = 0; rs1 = 0; rs2 = 0;
        rdata0 = 0; rdata1 = 0; mepc = 0; bufreg = 0; bad_pc = 0; csr_w = 0;
        ctrl_rd = 0; alu_rd = 0; csr_rd = 0; mem_rd = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_instr(input logic with_csr);
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            cnt_en = 1; csr_en = with_csr; csr_addr = 3'd2; csr_w = 8'(j); rd_wen = 1;
            rd_waddr = 5'd9; alu_en = 1; alu_rd = 8'h03; cnt_done = (j == 7);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b1; #1;
        rst_n = 1'b0;
        cnt_en = 1; rd_wen = 1; rd_waddr = 5'd5; csr_en = 1;
        #12;
        n_checks++; if (a_wen0 !== 1'b0) begin n_fail++; $display("FAIL reset a_wen0: got %b expected 0", a_wen0); end
        n_checks++; if (a_wen1 !== 1'b0) begin n_fail++; $display("FAIL reset a_wen1: got %b expected 0", a_wen1); end
        n_checks++; if (b_wen0 !== 1'b0) begin n_fail++; $display("FAIL reset b_wen0: got %b expected 0", b_wen0); end
        n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset b_busy: got %b expected 0", b_busy); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset a_busy: got %b expected 0", a_busy); end
        @(posedge clk); #1;
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_rd_stream;
        logic [31:0] pat;
        pat = 32'hA5A5A5A5;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            rd_waddr = 5'd5; rd_wen = 1; alu_en = 1; cnt_en = 1;
            alu_rd = {7'd0, pat[i]}; cnt_done = (i == 31); #1;
            n_checks++; if (a_wreg0 !== 6'd5) begin n_fail++; $display("FAIL rd a_wreg0 beat %0d: got %0d expected 5", i, a_wreg0); end
            n_checks++; if (a_wen0 !== 1'b1) begin n_fail++; $display("FAIL rd a_wen0 beat %0d: got %b expected 1", i, a_wen0); end
            n_checks++; if (a_wdata0 !== pat[i]) begin n_fail++; $display("FAIL rd a_wdata0 beat %0d: got %b expected %b", i, a_wdata0, pat[i]); end
            n_checks++; if (a_wen1 !== 1'b0) begin n_fail++; $display("FAIL rd a_wen1 beat %0d: got %b expected 0", i, a_wen1); end
        end
        @(posedge clk); #1;
        clear_inputs(); #1;
        n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL idle_done b_busy: got %b expected 0", b_busy); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rd_waddr = 5'd0; rd_wen = 1; alu_en = 1; alu_rd = 8'h01; cnt_en = 1; #1;
            n_checks++; if (a_wen0 !== 1'b0) begin n_fail++; $display("FAIL x0 a_wen0 beat %0d: got %b expected 0", i, a_wen0); end
        end
        clear_inputs();
        alu_rd = 8'h0F; #1;
        n_checks++; if (b_wdata0 !== 4'h0) begin n_fail++; $display("FAIL gated alu b_wdata0: got %h expected 0", b_wdata0); end
        ctrl_rd = 8'h05; #1;
        n_checks++; if (b_wdata0 !== 4'h5) begin n_fail++; $display("FAIL ctrl b_wdata0: got %h expected 5", b_wdata0); end
        mem_rd = 8'h0A; mem_en = 1; #1;
        n_checks++; if (b_wdata0 !== 4'hF) begin n_fail++; $display("FAIL mem_or b_wdata0: got %h expected f", b_wdata0); end
        clear_inputs();
    endtask

    task automatic test_csr;
        @(posedge clk); #1;
        csr_en = 1; csr_addr = 3'd6; rdata1 = 8'h01; rs1 = 5'd3; rs2 = 5'd7; #1;
        n_checks++; if (a_rreg1 !== 6'd38) begin n_fail++; $display("FAIL csr a_rreg1: got %0d expected 38", a_rreg1); end
        n_checks++; if (a_wreg1 !== 6'd38) begin n_fail++; $display("FAIL csr a_wreg1: got %0d expected 38", a_wreg1); end
        n_checks++; if (a_csr !== 1'b1) begin n_fail++; $display("FAIL csr a_csr: got %b expected 1", a_csr); end
        n_checks++; if (a_rreg0 !== 6'd3) begin n_fail++; $display("FAIL csr a_rreg0: got %0d expected 3", a_rreg0); end
        n_checks++; if (a_wen1 !== 1'b0) begin n_fail++; $display("FAIL csr a_wen1 no beat: got %b expected 0", a_wen1); end
        cnt_en = 1; #1;
        n_checks++; if (a_wen1 !== 1'b1) begin n_fail++; $display("FAIL csr a_wen1 beat: got %b expected 1", a_wen1); end
        n_checks++; if (b_wen1 !== 1'b0) begin n_fail++; $display("FAIL csr b_wen1 single port: got %b expected 0", b_wen1); end
        cnt_en = 0; csr_en = 0; #1;
        n_checks++; if (a_csr !== 1'b0) begin n_fail++; $display("FAIL csr off a_csr: got %b expected 0", a_csr); end
        n_checks++; if (a_rreg1 !== 6'd7) begin n_fail++; $display("FAIL csr off a_rreg1: got %0d expected 7", a_rreg1); end
        n_checks++; if (a_csr_pc !== 1'b1) begin n_fail++; $display("FAIL csr_pc a_csr_pc: got %b expected 1", a_csr_pc); end
        clear_inputs();
    endtask

    task automatic test_trap;
        logic [5:0] exp0, exp1, expb;
        @(posedge clk); #1;
        rd_waddr = 5'd5; rd_wen = 1; csr_en = 1; csr_addr = 3'd6; trap = 1;
        mtval_pc = 1; bad_pc = 8'h01; bufreg = 8'h00; mepc = 8'h01; #1;
        n_checks++; if (a_wreg0 !== 6'd35) begin n_fail++; $display("FAIL trap a_wreg0: got %0d expected 35", a_wreg0); end
        n_checks++; if (a_wreg1 !== 6'd34) begin n_fail++; $display("FAIL trap a_wreg1: got %0d expected 34", a_wreg1); end
        n_checks++; if (a_rreg1 !== 6'd33) begin n_fail++; $display("FAIL trap a_rreg1: got %0d expected 33", a_rreg1); end
        n_checks++; if (a_wdata0 !== 1'b1) begin n_fail++; $display("FAIL trap bad_pc a_wdata0: got %b expected 1", a_wdata0); end
        n_checks++; if (a_wdata1 !== 1'b1) begin n_fail++; $display("FAIL trap mepc a_wdata1: got %b expected 1", a_wdata1); end
        mtval_pc = 0; #1;
        n_checks++; if (a_wdata0 !== 1'b0) begin n_fail++; $display("FAIL trap bufreg a_wdata0: got %b expected 0", a_wdata0); end
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
            trap = 0; #1;
            exp0 = (k < 4) ? 6'd35 : 6'd5;
            exp1 = (k < 4) ? 6'd34 : 6'd38;
            expb = (k < 3) ? 6'd35 : 6'd5;
            n_checks++; if (a_wreg0 !== exp0) begin n_fail++; $display("FAIL hold a_wreg0 cyc %0d: got %0d expected %0d", k, a_wreg0, exp0); end
            n_checks++; if (a_wreg1 !== exp1) begin n_fail++; $display("FAIL hold a_wreg1 cyc %0d: got %0d expected %0d", k, a_wreg1, exp1); end
            n_checks++; if (a_rreg1 !== 6'd38) begin n_fail++; $display("FAIL hold a_rreg1 cyc %0d: got %0d expected 38", k, a_rreg1); end
            n_checks++; if (b_wreg0 !== expb) begin n_fail++; $display("FAIL hold b_wreg0 cyc %0d: got %0d expected %0d", k, b_wreg0, expb); end
        end
        clear_inputs();
    endtask

    task automatic test_priority;
        @(posedge clk); #1;
        mret = 1; csr_en = 1; csr_addr = 3'd7; #1;
        n_checks++; if (a_rreg1 !== 6'd34) begin n_fail++; $display("FAIL mret a_rreg1: got %0d expected 34", a_rreg1); end
        n_checks++; if (b_rreg1 !== 6'd34) begin n_fail++; $display("FAIL mret b_rreg1: got %0d expected 34", b_rreg1); end
        trap = 1; #1;
        n_checks++; if (a_rreg1 !== 6'd33) begin n_fail++; $display("FAIL trap_mret a_rreg1: got %0d expected 33", a_rreg1); end
        n_checks++; if (b_rreg1 !== 6'd33) begin n_fail++; $display("FAIL trap_mret b_rreg1: got %0d expected 33", b_rreg1); end
        trap = 0; mret = 0; #1;
        n_checks++; if (a_rreg1 !== 6'd39) begin n_fail++; $display("FAIL csr7 a_rreg1: got %0d expected 39", a_rreg1); end
        n_checks++; if (b_rreg1 !== 6'd35) begin n_fail++; $display("FAIL csr3 b_rreg1: got %0d expected 35", b_rreg1); end
        clear_inputs();
    endtask

    task automatic test_replay;
        logic [31:0] w;
        logic [3:0]  nib;
        w = 32'h12345678;
        do_reset();
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            cnt_en = 1; csr_en = 1; csr_addr = 3'd1; csr_w = {4'd0, w[4*j +: 4]};
            rd_wen = 1; rd_waddr = 5'd9; alu_en = 1; alu_rd = 8'h0C; cnt_done = (j == 7); #1;
            n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL cap b_busy beat %0d: got %b expected 0", j, b_busy); end
            n_checks++; if (b_wen0 !== 1'b1) begin n_fail++; $display("FAIL cap b_wen0 beat %0d: got %b expected 1", j, b_wen0); end
            n_checks++; if (b_wreg0 !== 6'd9) begin n_fail++; $display("FAIL cap b_wreg0 beat %0d: got %0d expected 9", j, b_wreg0); end
            n_checks++; if (b_wdata0 !== 4'hC) begin n_fail++; $display("FAIL cap b_wdata0 beat %0d: got %h expected c", j, b_wdata0); end
            n_checks++; if (b_wen1 !== 1'b0) begin n_fail++; $display("FAIL cap b_wen1 beat %0d: got %b expected 0", j, b_wen1); end
        end
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            clear_inputs();
            if (j == 1) begin cnt_en = 1; rd_wen = 1; rd_waddr = 5'd9; end
            #1;
            nib = w[4*j +: 4];
            n_checks++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL rep b_busy cyc %0d: got %b expected 1", j, b_busy); end
            n_checks++; if (b_wen0 !== 1'b1) begin n_fail++; $display("FAIL rep b_wen0 cyc %0d: got %b expected 1", j, b_wen0); end
            n_checks++; if (b_wreg0 !== 6'd33) begin n_fail++; $display("FAIL rep b_wreg0 cyc %0d: got %0d expected 33", j, b_wreg0); end
            n_checks++; if (b_wdata0 !== nib) begin n_fail++; $display("FAIL rep b_wdata0 cyc %0d: got %h expected %h", j, b_wdata0, nib); end
        end
        @(posedge clk); #1;
        clear_inputs(); #1;
        n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL rep end b_busy: got %b expected 0", b_busy); end
        n_checks++; if (b_wen0 !== 1'b0) begin n_fail++; $display("FAIL rep end b_wen0: got %b expected 0", b_wen0); end
    endtask

    task automatic test_reset_mid_replay;
        drive_instr(1'b1);
        #1;
        n_checks++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL mid r1 b_busy: got %b expected 1", b_busy); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL mid r3 b_busy: got %b expected 1", b_busy); end
        rst_n = 1'b0; #1;
        n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL mid rst b_busy: got %b expected 0", b_busy); end
        n_checks++; if (b_wen0 !== 1'b0) begin n_fail++; $display("FAIL mid rst b_wen0: got %b expected 0", b_wen0); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_instr(1'b0);
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL no_csr b_busy cyc %0d: got %b expected 0", k, b_busy); end
            n_checks++; if (b_wen0 !== 1'b0) begin n_fail++; $display("FAIL no_csr b_wen0 cyc %0d: got %b expected 0", k, b_wen0); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_rd_stream();
        test_csr();
        test_trap();
        test_priority();
        test_replay();
        test_reset_mid_replay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
